// File: rtl/uart_tx_frame.sv
// Parallel-in UART transmitter: valid/ready word intake, LSB-first framing with
// optional parity and one or two stop bits, programmable bit time and link abort.
module uart_tx_frame #(
    parameter int DATA_BITS    = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 valid,
    output logic                 ready,
    output logic                 txd,
    output logic                 busy,
    output logic                 done
);

    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);
    localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t               state_q;
    logic [BW-1:0]        baud_q;
    logic [CW-1:0]        bit_cnt_q;
    logic [DATA_BITS-1:0] shift_q;
    logic [DATA_BITS-1:0] word_q;
    logic                 txd_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 adv_s;

    // Parity is taken from the word as captured, independent of the shifter.
    function automatic logic parity_bit(input logic [DATA_BITS-1:0] w);
        if (PARITY == 2) begin
            parity_bit = ~^w;
        end else begin
            parity_bit = ^w;
        end
    endfunction

    assign adv_s = (baud_q == BAUD_LAST);
    assign ready = (state_q == S_IDLE) && enable && !rst;
    assign txd   = txd_q;
    assign busy  = busy_q;
    assign done  = done_q;

    // Frame sequencer: bit timing, shifting and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            baud_q    <= BW'(0);
            bit_cnt_q <= CW'(0);
            shift_q   <= DATA_BITS'(0);
            word_q    <= DATA_BITS'(0);
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (!enable) begin
            state_q   <= S_IDLE;
            baud_q    <= BW'(0);
            bit_cnt_q <= CW'(0);
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (valid) begin
                        shift_q   <= data;
                        word_q    <= data;
                        baud_q    <= BW'(0);
                        bit_cnt_q <= CW'(0);
                        txd_q     <= 1'b0;
                        busy_q    <= 1'b1;
                        state_q   <= S_START;
                    end else begin
                        txd_q <= 1'b1;
                    end
                end
                S_START: begin
                    if (adv_s) begin
                        baud_q  <= BW'(0);
                        txd_q   <= shift_q[0];
                        state_q <= S_DATA;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (adv_s) begin
                        baud_q <= BW'(0);
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_q <= CW'(0);
                            if (PARITY != 0) begin
                                txd_q   <= parity_bit(word_q);
                                state_q <= S_PARITY;
                            end else begin
                                txd_q   <= 1'b1;
                                state_q <= S_STOP;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            shift_q   <= {1'b0, shift_q[DATA_BITS-1:1]};
                            txd_q     <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (adv_s) begin
                        baud_q  <= BW'(0);
                        txd_q   <= 1'b1;
                        state_q <= S_STOP;
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (adv_s) begin
                        baud_q <= BW'(0);
                        if (bit_cnt_q == STOP_LAST) begin
                            bit_cnt_q <= CW'(0);
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= S_IDLE;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                    end else begin
                        baud_q <= baud_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    txd_q   <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Scoreboard bench for uart_tx_frame: four parameter variants share stimulus,
// a monitor decodes the selected line cycle by cycle against queued frames.
module tb_uart_tx_frame;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, enable, valid;
    logic [7:0] data;
    logic [1:0] sel;
    logic       valid_s [4];
    logic       ready_s [4];
    logic       txd_s   [4];
    logic       busy_s  [4];
    logic       done_s  [4];
    logic       txd_m, busy_m, ready_m, done_m;

    int checks = 0;
    int errors = 0;
    bit mon_busy = 1'b0;

    typedef struct {
        logic [15:0] bits;
        int          nbits;
        int          max_wait;
    } exp_t;
    exp_t exp_q[$];

    assign valid_s[0] = valid && (sel == 2'd0);
    assign valid_s[1] = valid && (sel == 2'd1);
    assign valid_s[2] = valid && (sel == 2'd2);
    assign valid_s[3] = valid && (sel == 2'd3);
    assign txd_m   = txd_s[sel];
    assign busy_m  = busy_s[sel];
    assign ready_m = ready_s[sel];
    assign done_m  = done_s[sel];

    uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .enable(enable), .data(data), .valid(valid_s[0]),
        .ready(ready_s[0]), .txd(txd_s[0]), .busy(busy_s[0]), .done(done_s[0]));
    uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .rst(rst), .enable(enable), .data(data), .valid(valid_s[1]),
        .ready(ready_s[1]), .txd(txd_s[1]), .busy(busy_s[1]), .done(done_s[1]));
    uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) u_8o1 (
        .clk(clk), .rst(rst), .enable(enable), .data(data), .valid(valid_s[2]),
        .ready(ready_s[2]), .txd(txd_s[2]), .busy(busy_s[2]), .done(done_s[2]));
    uart_tx_frame #(.DATA_BITS(7), .CLKS_PER_BIT(4), .PARITY(0), .STOP_BITS(2)) u_7n2 (
        .clk(clk), .rst(rst), .enable(enable), .data(data[6:0]), .valid(valid_s[3]),
        .ready(ready_s[3]), .txd(txd_s[3]), .busy(busy_s[3]), .done(done_s[3]));

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: find the start bit, then check every cycle of the frame and the done cycle.
    initial begin
        exp_t e;
        int   wait_cnt;
        wait_cnt = 0;
        forever begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                wait_cnt = 0;
                continue;
            end
            if (txd_m !== 1'b0) begin
                wait_cnt++;
                if (wait_cnt > exp_q[0].max_wait) begin
                    chk1("start_timeout", txd_m, 1'b0);
                    void'(exp_q.pop_front());
                    wait_cnt = 0;
                end
                continue;
            end
            e = exp_q.pop_front();
            wait_cnt = 0;
            mon_busy = 1'b1;
            for (int c = 0; c < e.nbits * 4; c++) begin
                if (c > 0) @(negedge clk);
                chk1("txd_bit",     txd_m,   e.bits[c / 4]);
                chk1("busy_frame",  busy_m,  1'b1);
                chk1("ready_frame", ready_m, 1'b0);
                chk1("done_frame",  done_m,  1'b0);
            end
            @(negedge clk);
            chk1("done_pulse", done_m,  1'b1);
            chk1("done_busy",  busy_m,  1'b0);
            chk1("done_ready", ready_m, 1'b1);
            chk1("done_txd",   txd_m,   1'b1);
            mon_busy = 1'b0;
        end
    end

    task automatic push(input logic [15:0] bits, input int nbits, input int max_wait);
        exp_t e;
        e.bits = bits;
        e.nbits = nbits;
        e.max_wait = max_wait;
        exp_q.push_back(e);
    endtask

    task automatic send(input logic [1:0] id, input logic [7:0] d,
                        input logic [15:0] bits, input int nbits);
        @(negedge clk);
        sel = id;
        data = d;
        valid = 1'b1;
        push(bits, nbits, 2);
        @(posedge clk);
        #1;
        valid = 1'b0;
        data = ~d;
    endtask

    task automatic send_untracked(input logic [7:0] d);
        @(negedge clk);
        sel = 2'd0;
        data = d;
        valid = 1'b1;
        @(posedge clk);
        #1;
        valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || mon_busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk1("drain_timeout", n >= 200, 1'b0);
        @(negedge clk);
    endtask

    // Directed stimulus; frame vectors are listed bit 0 = first bit on the line.
    initial begin
        int n;
        rst = 1'b1; enable = 1'b1; valid = 1'b0; data = 8'h00; sel = 2'd0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk1("rst_txd",   txd_s[i],   1'b1);
            chk1("rst_busy",  busy_s[i],  1'b0);
            chk1("rst_done",  done_s[i],  1'b0);
            chk1("rst_ready", ready_s[i], 1'b0);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) chk1("idle_ready", ready_s[i], 1'b1);

        send(2'd0, 8'hA5, 16'h034A, 10); drain();
        send(2'd1, 8'h07, 16'h060E, 11); drain();
        send(2'd2, 8'h07, 16'h040E, 11); drain();
        send(2'd3, 8'h55, 16'h03AA, 10); drain();

        // Back-to-back: second start must follow the done cycle immediately.
        @(negedge clk);
        sel = 2'd0; data = 8'h01; valid = 1'b1;
        push(16'h0202, 10, 2);
        @(posedge clk);
        #1;
        data = 8'h80;
        push(16'h0300, 10, 0);
        n = 0;
        while (done_m !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk1("b2b_done_seen", done_m, 1'b1);
        @(posedge clk);
        #1;
        valid = 1'b0;
        drain();

        // Abort during data bit 3.
        send_untracked(8'hA5);
        repeat (18) @(negedge clk);
        chk1("abort_pre_txd",  txd_m,  1'b0);
        chk1("abort_pre_busy", busy_m, 1'b1);
        enable = 1'b0;
        @(negedge clk);
        chk1("abort_txd",   txd_m,   1'b1);
        chk1("abort_busy",  busy_m,  1'b0);
        chk1("abort_done",  done_m,  1'b0);
        chk1("abort_ready", ready_m, 1'b0);
        repeat (3) begin
            @(negedge clk);
            chk1("abort_no_done", done_m, 1'b0);
        end
        enable = 1'b1;
        #1;
        chk1("abort_ready_back", ready_m, 1'b1);
        send(2'd0, 8'h3C, 16'h0278, 10); drain();

        // Reset in the middle of the stop bit.
        send_untracked(8'hA5);
        repeat (38) @(negedge clk);
        chk1("rstmid_pre_txd",  txd_m,  1'b1);
        chk1("rstmid_pre_busy", busy_m, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        chk1("rstmid_txd",   txd_m,   1'b1);
        chk1("rstmid_busy",  busy_m,  1'b0);
        chk1("rstmid_done",  done_m,  1'b0);
        chk1("rstmid_ready", ready_m, 1'b0);
        rst = 1'b0;
        #1;
        chk1("rstmid_ready_back", ready_m, 1'b1);
        repeat (4) begin
            @(negedge clk);
            chk1("rstmid_no_done", done_m, 1'b0);
        end
        send(2'd0, 8'h01, 16'h0202, 10); drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
